// File: rtl/saradc_pkg.sv
// saradc_pkg: shared types and helpers for the saradc sequencer.
package saradc_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CAL  = 3'd1,
      ST_CONV = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Default saradc result width
   localparam int ADC_W_DEF = 10;

   // Accumulator must hold 2^avg_log2 full-scale samples without wrapping
   function automatic int acc_width(input int adc_w, input int avg_log2);
      return adc_w + avg_log2;
   endfunction

endpackage

// File: rtl/saradc_ctrl_acc.sv
// saradc_ctrl_acc: burst accumulator, sample counter and shift-average.
// clr starts a new burst (or discards a partial one); add folds in one sample.
module saradc_ctrl_acc
   import saradc_pkg::*;
#(
   parameter int ADC_W    = ADC_W_DEF,
   parameter int AVG_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             add,
   input  logic [ADC_W-1:0] sample,
   output logic             last,
   output logic [ADC_W-1:0] avg
);

   localparam int ACC_W = acc_width(ADC_W, AVG_LOG2);
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next accumulator / count: clear has priority over a sample
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clr) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (add) begin
         acc_d = acc_q + ACC_W'(sample);
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Accumulator and sample counter registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   // The sample being added now completes the burst
   assign last = add & (cnt_q == LAST_IDX);
   // Truncating average of the completed burst
   assign avg  = ADC_W'(acc_q >> AVG_LOG2);

endmodule

// File: rtl/saradc_ctrl.sv
// saradc_ctrl: calibration / conversion sequencer for the saradc macro with
// burst averaging and a one-entry valid/ready result register.
// Optional watchdog: define SARADC_CTRL_WDOG_EN (adds the TIMEOUT parameter).
module saradc_ctrl
   import saradc_pkg::*;
#(
   parameter int ADC_W    = ADC_W_DEF,
   parameter int AVG_LOG2 = 2,
   parameter int PERIOD_W = 16
`ifdef SARADC_CTRL_WDOG_EN
   ,
   parameter int TIMEOUT  = 4096
`endif
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic                cont,
   input  logic [PERIOD_W-1:0] period,
   input  logic                cal_req,
   input  logic                clr_ovr,
   output logic                adc_en,
   output logic                adc_cal,
   input  logic                adc_valid,
   input  logic [ADC_W-1:0]    adc_result,
   output logic [ADC_W-1:0]    dout,
   output logic                dout_valid,
   input  logic                dout_ready,
   output logic                busy,
   output logic                cal_done,
   output logic                overrun,
   output logic                timeout
);

   state_e              state_q, state_d;
   logic                prev_valid_q;
   logic                cal_pend_q, cal_pend_d;
   logic                start_pend_q, start_pend_d;
   logic                tick_pend_q, tick_pend_d;
   logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
   logic [ADC_W-1:0]    dout_q, dout_d;
   logic                dout_valid_q, dout_valid_d;
   logic                cal_done_q, cal_done_d;
   logic                overrun_q, overrun_d;

   logic                vedge, tick, wd_hit;
   logic                acc_clr, acc_add, acc_last;
   logic [ADC_W-1:0]    acc_avg;
   logic [PERIOD_W-1:0] period_m1;

   assign vedge     = adc_valid & ~prev_valid_q;
   assign period_m1 = (period == '0) ? '0 : period - 1'b1;
   assign tick      = cont & (per_cnt_q == period_m1);
   assign acc_add   = (state_q == ST_CONV) & vedge;

   saradc_ctrl_acc #(
      .ADC_W   (ADC_W),
      .AVG_LOG2(AVG_LOG2)
   ) u_acc (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (acc_clr),
      .add   (acc_add),
      .sample(adc_result),
      .last  (acc_last),
      .avg   (acc_avg)
   );

   // Period counter: free-runs while cont is high, wraps on tick
   always_comb begin
      per_cnt_d = per_cnt_q + 1'b1;
      if (!cont || tick) per_cnt_d = '0;
   end

   // FSM next state, request bookkeeping, saradc pins and result register
   always_comb begin
      state_d      = state_q;
      cal_pend_d   = cal_pend_q | cal_req;
      start_pend_d = start_pend_q | start;
      tick_pend_d  = cont & (tick_pend_q | tick);
      acc_clr      = 1'b0;
      adc_en       = 1'b0;
      adc_cal      = 1'b0;
      cal_done_d   = cal_done_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q & ~dout_ready;
      overrun_d    = overrun_q & ~clr_ovr;
      case (state_q)
         ST_IDLE: begin
            if (cal_pend_q) begin
               state_d = ST_CAL;
            end else if (start | start_pend_q) begin
               state_d      = ST_CONV;
               start_pend_d = 1'b0;
               acc_clr      = 1'b1;
            end else if (tick | tick_pend_q) begin
               state_d     = ST_CONV;
               tick_pend_d = 1'b0;
               acc_clr     = 1'b1;
            end
         end
         ST_CAL: begin
            adc_en  = 1'b1;
            adc_cal = 1'b1;
            if (wd_hit) begin
               state_d = ST_IDLE;
            end else if (vedge) begin
               state_d    = ST_IDLE;
               cal_done_d = 1'b1;
               cal_pend_d = cal_req;
            end
         end
         ST_CONV: begin
            adc_en = 1'b1;
            if (wd_hit) begin
               state_d = ST_IDLE;
               acc_clr = 1'b1;
            end else if (vedge) begin
               state_d = acc_last ? ST_DONE : ST_GAP;
            end
         end
         ST_GAP: begin
            state_d = ST_CONV;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (!dout_valid_q || dout_ready) begin
               dout_d       = acc_avg;
               dout_valid_d = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state registers; reset leaves a calibration pending
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         prev_valid_q <= 1'b0;
         cal_pend_q   <= 1'b1;
         start_pend_q <= 1'b0;
         tick_pend_q  <= 1'b0;
         per_cnt_q    <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         cal_done_q   <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_valid_q <= adc_valid;
         cal_pend_q   <= cal_pend_d;
         start_pend_q <= start_pend_d;
         tick_pend_q  <= tick_pend_d;
         per_cnt_q    <= per_cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         cal_done_q   <= cal_done_d;
         overrun_q    <= overrun_d;
      end
   end

`ifdef SARADC_CTRL_WDOG_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            timeout_q, timeout_d;

   // Watchdog: counts cycles in CAL/CONV since the last valid edge or state entry
   always_comb begin
      wd_d      = '0;
      wd_hit    = 1'b0;
      timeout_d = timeout_q & ~clr_ovr;
      if ((state_q == ST_CAL || state_q == ST_CONV) && !vedge) begin
         if (wd_q == WD_W'(TIMEOUT - 1)) begin
            wd_hit    = 1'b1;
            timeout_d = 1'b1;
         end else begin
            wd_d = wd_q + 1'b1;
         end
      end
   end

   // Watchdog counter and sticky timeout flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   // No watchdog: wait on adc_valid indefinitely
   assign wd_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = (state_q != ST_IDLE);
   assign cal_done   = cal_done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_saradc_ctrl.sv
// tb_saradc_ctrl: directed bench for saradc_ctrl with a behavioural saradc model.
// Define SARADC_CTRL_WDOG_EN to also exercise the watchdog (TIMEOUT=64).
module tb_saradc_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic        cont = 1'b0;
   logic [15:0] period = 16'd0;
   logic        cal_req = 1'b0;
   logic        clr_ovr = 1'b0;
   logic        adc_en, adc_cal;
   logic        adc_valid = 1'b0;
   logic [9:0]  adc_result = 10'd0;
   logic [9:0]  dout;
   logic        dout_valid;
   logic        dout_ready = 1'b0;
   logic        busy, cal_done, overrun, timeout;

   int checks = 0;
   int errors = 0;

   // saradc model state
   int         adc_lat  = 20;
   bit         model_on = 1'b1;
   int         m_cnt    = 0;
   int         res_idx  = 0;
   int         n_samp   = 0;
   logic [9:0] res_tab[4];

   always #5 clk = ~clk;

   saradc_ctrl #(
      .ADC_W   (10),
      .AVG_LOG2(2),
      .PERIOD_W(16)
`ifdef SARADC_CTRL_WDOG_EN
      ,
      .TIMEOUT (64)
`endif
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .cont      (cont),
      .period    (period),
      .cal_req   (cal_req),
      .clr_ovr   (clr_ovr),
      .adc_en    (adc_en),
      .adc_cal   (adc_cal),
      .adc_valid (adc_valid),
      .adc_result(adc_result),
      .dout      (dout),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready),
      .busy      (busy),
      .cal_done  (cal_done),
      .overrun   (overrun),
      .timeout   (timeout)
   );

   // Behavioural saradc: valid rises adc_lat cycles after en, drops when en drops
   always @(negedge clk) begin
      if (!rstn || !adc_en) begin
         m_cnt     = 0;
         adc_valid = 1'b0;
      end else if (!adc_valid && model_on) begin
         if (m_cnt >= adc_lat - 1) begin
            adc_valid  = 1'b1;
            adc_result = res_tab[res_idx];
            res_idx    = (res_idx + 1) % 4;
            n_samp++;
         end else begin
            m_cnt++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end else begin
         $display("check %s value=%0d ok", tag, obs);
      end
   endtask

   task automatic set_results(input logic [9:0] a, input logic [9:0] b,
                              input logic [9:0] c, input logic [9:0] d);
      res_tab[0] = a;
      res_tab[1] = b;
      res_tab[2] = c;
      res_tab[3] = d;
      res_idx    = 0;
      n_samp     = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic consume();
      dout_ready = 1'b1;
      @(negedge clk);
      dout_ready = 1'b0;
   endtask

   initial begin
      int n;
      int n_cal;
      int gaps;
      int en_cycles;

      set_results(10'd0, 10'd0, 10'd0, 10'd0);

      // 1: reset state, then power-on calibration
      @(negedge clk);
      @(negedge clk);
      chk("rst_adc_en", adc_en, 0);
      chk("rst_adc_cal", adc_cal, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_cal_done", cal_done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout", timeout, 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("t1_cal_active", {adc_en, adc_cal}, 2'b11);
      n_cal = 0;
      n = 0;
      while (!cal_done && n < 300) begin
         if (adc_cal) n_cal++;
         @(negedge clk);
         n++;
      end
      chk("t1_cal_done", cal_done, 1);
      chk("t1_cal_len_ge20", (n_cal >= 20), 1);
      chk("t1_cal_dropped", adc_cal, 0);
      chk("t1_no_dout", dout_valid, 0);

      // 2: single-shot burst, 100,101,102,104 -> 101
      adc_lat = 3;
      set_results(10'd100, 10'd101, 10'd102, 10'd104);
      pulse_start();
      chk("t2_en_next_cycle", adc_en, 1);
      gaps = 0;
      n = 0;
      while (!dout_valid && n < 300) begin
         if (busy && !adc_en) gaps++;
         @(negedge clk);
         n++;
      end
      chk("t2_dout_valid", dout_valid, 1);
      chk("t2_dout", dout, 101);
      chk("t2_gap_plus_done_cycles", gaps, 4);
      consume();
      chk("t2_dout_consumed", dout_valid, 0);

      // 3: continuous mode with a stalled consumer -> overrun
      set_results(10'd200, 10'd200, 10'd200, 10'd200);
      period = 16'd200;
      cont   = 1'b1;
      n = 0;
      while (!dout_valid && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("t3_first_dout_valid", dout_valid, 1);
      chk("t3_first_dout", dout, 200);
      chk("t3_no_overrun_yet", overrun, 0);
      set_results(10'd300, 10'd300, 10'd300, 10'd300);
      n = 0;
      while (!overrun && n < 600) begin
         @(negedge clk);
         n++;
      end
      cont = 1'b0;
      chk("t3_overrun_set", overrun, 1);
      chk("t3_dout_held", dout, 200);
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      clr_ovr = 1'b1;
      @(negedge clk);
      clr_ovr = 1'b0;
      chk("t3_overrun_cleared", overrun, 0);
      chk("t3_dout_still_valid", dout_valid, 1);
      consume();
      chk("t3_dout_consumed", dout_valid, 0);

      // 4: cal_req during sample 2 -> burst completes, then CAL
      set_results(10'd40, 10'd40, 10'd40, 10'd40);
      pulse_start();
      n = 0;
      while (!(n_samp == 1 && adc_en && !adc_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t4_in_sample2", n_samp, 1);
      cal_req = 1'b1;
      @(negedge clk);
      cal_req = 1'b0;
      n = 0;
      while (!dout_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t4_dout_valid", dout_valid, 1);
      chk("t4_dout", dout, 40);
      chk("t4_no_cal_before_dout", adc_cal, 0);
      n = 0;
      while (!adc_cal && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("t4_recal", adc_cal, 1);
      consume();
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t4_idle_after_cal", busy, 0);

      // 5: async reset mid-conversion
      pulse_start();
      chk("t5_conv_running", adc_en, 1);
      #2 rstn = 1'b0;
      #1;
      chk("t5_rst_adc_en", adc_en, 0);
      chk("t5_rst_outputs", {busy, dout_valid, cal_done, overrun, timeout}, 5'b0);
      @(negedge clk);
      rstn = 1'b1;
      n = 0;
      while (!adc_cal && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("t5_recal_after_rst", adc_cal, 1);
      n = 0;
      while (!cal_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t5_cal_done_again", cal_done, 1);

`ifdef SARADC_CTRL_WDOG_EN
      // 6: watchdog abort with a silent saradc
      model_on = 1'b0;
      pulse_start();
      en_cycles = adc_en ? 1 : 0;
      n = 0;
      while (!timeout && n < 300) begin
         @(negedge clk);
         if (adc_en) en_cycles++;
         n++;
      end
      chk("t6_timeout", timeout, 1);
      chk("t6_busy_clear", busy, 0);
      chk("t6_en_cycles", en_cycles, 64);
      clr_ovr = 1'b1;
      @(negedge clk);
      clr_ovr = 1'b0;
      chk("t6_timeout_cleared", timeout, 0);
      model_on = 1'b1;
`else
      en_cycles = 0;
      chk("t6_timeout_tied_low", timeout + en_cycles, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
